// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scanning channel multiplexer.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_core.sv
// Combinational N_CH:1 mux of DW-bit channels; flags indices with no channel behind them.
module mux_core #(
  parameter int unsigned N_CH  = 64,
  parameter int unsigned DW    = 1,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*DW-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [DW-1:0]      data_o,
  output logic               oob_o
);

  // Compare against every legal index so non power-of-2 counts fall through to oob.
  always_comb begin
    data_o = '0;
    oob_o  = 1'b1;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (sel_i == SEL_W'(c)) begin
        data_o = data_i[c*DW +: DW];
        oob_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_mux_seq.sv
// Registered N_CH:1 channel mux with a manual select path and an auto-scan sequencer.
module scan_mux_seq
  import scan_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 64,
  parameter int unsigned DW    = 1,
  parameter int unsigned DWELL = 1,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*DW-1:0]   in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 start,
  output logic [DW-1:0]        out,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DCW = $clog2(DWELL + 1);
  localparam logic [DCW-1:0]   DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(N_CH - 1);

  scan_state_t      state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DCW-1:0]   dwell_q, dwell_d;
  logic [DW-1:0]    out_q, out_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;

  logic [SEL_W-1:0] mux_sel;
  logic [DW-1:0]    mux_data;
  logic             mux_oob;
  logic             scan_go;
  logic             dwell_end;
  logic             scan_last;

  assign scan_go   = start && (mode == MODE_SCAN);
  assign dwell_end = (dwell_q == DWELL_LAST);
  assign scan_last = dwell_end && (idx_q == IDX_LAST);

  // The single mux is shared: scan index while scanning, external select otherwise.
  assign mux_sel = (state_q == SCAN) ? idx_q : sel;

  mux_core #(
    .N_CH  (N_CH),
    .DW    (DW),
    .SEL_W (SEL_W)
  ) u_mux_core (
    .data_i (in),
    .sel_i  (mux_sel),
    .data_o (mux_data),
    .oob_o  (mux_oob)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (scan_go) state_d = SCAN;
      SCAN:    if (scan_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  // Dwell and channel index counters; the index saturates at the last channel.
  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    unique case (state_q)
      IDLE: begin
        if (scan_go) begin
          idx_d   = '0;
          dwell_d = '0;
        end
      end
      SCAN: begin
        if (dwell_end) begin
          dwell_d = '0;
          if (!scan_last) idx_d = idx_q + SEL_W'(1);
        end else begin
          dwell_d = dwell_q + DCW'(1);
        end
      end
      default: ;
    endcase
  end

  // Data path registers hold their value through DONE so out keeps the last channel.
  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    cur_sel_d = cur_sel_q;
    if (state_q != DONE) begin
      out_d     = mux_oob ? '0 : mux_data;
      valid_d   = !mux_oob;
      cur_sel_d = mux_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      dwell_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      cur_sel_q <= '0;
    end else begin
      idx_q     <= idx_d;
      dwell_q   <= dwell_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign cur_sel   = cur_sel_q;

endmodule
